glb_stream_sched: RTL and testbench

Round-robin scheduler that shares one 17-bit GLB-to-fabric write channel among NUM_SRC stream sources (GLB bank read ports or bench-side stream models). It starts traffic a fixed number of cycles after the configuration flush and grants the channel in bounded bursts. It raises a global done once every source has signalled done. It sits between the GLB stream sources and the single IO tile input of the array.

---
 rtl/glb_sched_pkg.sv | 14 +
 rtl/glb_stream_sched_rr_pick.sv | 29 ++
 rtl/glb_stream_sched.sv | 162 ++++++++++++++++
 tb/tb_glb_stream_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_sched_pkg.sv
// Shared types and constants for the GLB stream scheduler and its picker.
package glb_sched_pkg;

  localparam int GLB_BEAT_W = 17;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ARB,
    BURST,
    DONE
  } sched_state_t;

endpackage

// File: rtl/glb_stream_sched_rr_pick.sv
// Rotating-priority picker: returns the first asserted req at or after ptr,
// wrapping past N-1 back to 0. Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back toward ptr so the nearest one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/glb_stream_sched.sv
// Round-robin scheduler sharing one GLB-to-fabric write channel among NUM_SRC
// stream sources, with a post-flush start delay and bounded bursts.
//
// state | meaning
// IDLE  | parked until flush falls
// WAIT  | start-delay down-counter running to terminal count
// ARB   | one-cycle pick of the next valid, unfinished source
// BURST | granted source drives the channel for up to BURST_LEN beats
// DONE  | every source finished; all_done held until flush
module glb_stream_sched
  import glb_sched_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int BURST_LEN   = 8,
  parameter int START_DELAY = 3,
  localparam int ID_W       = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_SRC*GLB_BEAT_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_done,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [GLB_BEAT_W-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_W-1:0]               grant_id,
  output logic                          all_done
);

  localparam logic [7:0]      LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [3:0]      DLY_LOAD  = 4'(START_DELAY);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_SRC - 1);

  sched_state_t state, state_nxt;

  logic                  flush_q;
  logic [3:0]            dly_cnt;
  logic [7:0]            beat_cnt;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       grant_q;
  logic [ID_W-1:0]       grant_inc;
  logic [NUM_SRC-1:0]    req;
  logic                  pick_found;
  logic [ID_W-1:0]       pick_idx;
  logic [GLB_BEAT_W-1:0] data_arr [NUM_SRC];
  logic                  cur_done;
  logic                  beat;
  logic                  burst_end;

  // Finished sources are masked out so they can never win arbitration.
  assign req = src_valid & ~src_done;

  rr_pick #(
    .N  (NUM_SRC),
    .IW (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      data_arr[i] = src_data[GLB_BEAT_W*i +: GLB_BEAT_W];
    end
  end

  assign cur_done  = src_done[grant_q];
  assign grant_inc = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);
  assign grant_id  = grant_q;
  assign all_done  = (state == DONE);

  // src_done on the granted source kills the handshake in the same cycle,
  // so a beat coinciding with done is dropped rather than half-delivered.
  always_comb begin
    state_nxt = state;
    out_data  = '0;
    out_valid = 1'b0;
    src_ready = '0;
    beat      = 1'b0;
    burst_end = 1'b0;
    case (state)
      IDLE: begin
        if (flush_q && !flush) state_nxt = WAIT;
      end
      WAIT: begin
        if (dly_cnt == 4'd0) state_nxt = ARB;
      end
      ARB: begin
        if (pick_found)     state_nxt = BURST;
        else if (&src_done) state_nxt = DONE;
      end
      BURST: begin
        out_data = data_arr[grant_q];
        if (!cur_done && !flush) begin
          out_valid          = src_valid[grant_q];
          src_ready[grant_q] = out_ready;
        end
        beat      = out_valid & out_ready;
        burst_end = cur_done | (beat & (beat_cnt == LAST_BEAT));
        if (burst_end) state_nxt = ARB;
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q  <= 1'b0;
      dly_cnt  <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
      grant_q  <= '0;
    end else begin
      flush_q <= flush;
      if (flush) begin
        dly_cnt  <= '0;
        beat_cnt <= '0;
        rr_ptr   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (state_nxt == WAIT) dly_cnt <= DLY_LOAD;
          end
          WAIT: begin
            if (dly_cnt != 4'd0) dly_cnt <= dly_cnt - 4'd1;
          end
          ARB: begin
            if (pick_found) begin
              grant_q  <= pick_idx;
              beat_cnt <= '0;
            end
          end
          BURST: begin
            if (burst_end)  rr_ptr   <= grant_inc;
            else if (beat)  beat_cnt <= beat_cnt + 8'd1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glb_stream_sched.sv
// Directed bench for glb_stream_sched: NUM_SRC=4, BURST_LEN=4, START_DELAY=3.
module tb_glb_stream_sched;

  localparam int NS = 4;
  localparam int BL = 4;
  localparam int SD = 3;
  localparam int W  = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush;
  logic [NS*W-1:0] src_data;
  logic [NS-1:0] src_valid;
  logic [NS-1:0] src_done;
  logic [NS-1:0] src_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    grant_id;
  logic          all_done;

  int checks = 0;
  int errors = 0;
  int n    [NS];
  int base [NS];
  int lim  [NS];
  int nb;

  always #5 clk = ~clk;

  glb_stream_sched #(
    .NUM_SRC     (NS),
    .BURST_LEN   (BL),
    .START_DELAY (SD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_done  (src_done),
    .src_ready (src_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .all_done  (all_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      src_data[W*i +: W] = W'(base[i] + n[i]);
      src_valid[i]       = (n[i] < lim[i]);
    end
  endtask

  task automatic setup(input int b0, input int l0, input int b1, input int l1,
                       input int b2, input int l2, input int b3, input int l3);
    base[0] = b0; lim[0] = l0;
    base[1] = b1; lim[1] = l1;
    base[2] = b2; lim[2] = l2;
    base[3] = b3; lim[3] = l3;
    for (int i = 0; i < NS; i++) n[i] = 0;
    nb = 0;
  endtask

  function automatic int beat_src();
    int s;
    s = -1;
    if (out_valid && out_ready)
      for (int i = 0; i < NS; i++)
        if (src_ready[i]) s = i;
    return s;
  endfunction

  // Detects a handshake, checks its data against the source model, consumes it.
  task automatic take_beat(output int s);
    s = beat_src();
    if (s >= 0) begin
      chk("beat_data", 32'(out_data), base[s] + n[s]);
      n[s]++;
    end
  endtask

  // Leaves the caller in the first cycle with flush low and flush_q high.
  task automatic flush_start();
    tick();
    flush = 1'b1;
    drive();
    #1;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ready", 32'(src_ready), 0);
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int s;
    int bc3 [5];
    bc3 = '{6, 9, 10, 11, 13};
    flush     = 1'b0;
    out_ready = 1'b0;
    src_done  = '0;
    src_valid = '0;
    src_data  = '0;
    setup(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_all_done", 32'(all_done), 0);
    tick();
    tick();
    rst_n = 1'b1;
    setup('h100, 10, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      drive();
    end
    #1;
    chk("idle_no_flush_valid", 32'(out_valid), 0);
    chk("idle_no_flush_ready", 32'(src_ready), 0);

    // Test 1: single source, 10 beats -> bursts 4/4/2, then all done
    setup('h100, 10, 0, 0, 0, 0, 0, 0);
    src_done = '0;
    flush_start();
    for (int r = 0; r <= 20; r++) begin
      if (r > 0) tick();
      src_done = (n[0] >= 10) ? 4'hF : 4'h0;
      drive();
      #1;
      take_beat(s);
      if (s >= 0) begin
        chk("t1_src", s, 0);
        chk("t1_cycle", r, 6 + (nb / 4) * 5 + nb % 4);
        nb++;
      end
      if (r == 18) chk("t1_done_ready", 32'(src_ready), 0);
      if (r == 19) chk("t1_all_done_lo", 32'(all_done), 0);
      if (r == 20) chk("t1_all_done_hi", 32'(all_done), 1);
    end
    chk("t1_beats", nb, 10);

    // Test 2: two sources always valid -> 0,1,0,1 with 4 beats each
    setup('h200, 100, 'h300, 100, 0, 0, 0, 0);
    src_done = '0;
    flush_start();
    for (int r = 0; r <= 24; r++) begin
      if (r > 0) tick();
      drive();
      #1;
      if (r == 0) chk("t2_all_done_cleared", 32'(all_done), 0);
      take_beat(s);
      if (s >= 0) begin
        chk("t2_src", s, (nb / 4) % 2);
        chk("t2_grant", 32'(grant_id), (nb / 4) % 2);
        chk("t2_ready", 32'(src_ready), 1 << ((nb / 4) % 2));
        chk("t2_cycle", r, 6 + (nb / 4) * 5 + nb % 4);
        nb++;
      end
    end
    chk("t2_beats", nb, 16);

    // Test 3: backpressure 1,0,0,1 inside a burst
    setup('h400, 100, 0, 0, 0, 0, 0, 0);
    flush_start();
    for (int r = 0; r <= 13; r++) begin
      if (r > 0) tick();
      out_ready = !(r == 7 || r == 8);
      drive();
      #1;
      take_beat(s);
      if (s >= 0) begin
        if (nb < 5) chk("t3_cycle", r, bc3[nb]);
        nb++;
      end
      if (r == 7 || r == 8) begin
        chk("t3_stall_valid", 32'(out_valid), 1);
        chk("t3_stall_ready", 32'(src_ready), 0);
        chk("t3_stall_data", 32'(out_data), 'h401);
      end
      if (r == 12) chk("t3_bubble", 32'(out_valid), 0);
    end
    chk("t3_beats", nb, 5);
    out_ready = 1'b1;

    // Test 4: src2 raises done after one beat
    setup(0, 0, 0, 0, 'h500, 100, 'h600, 100);
    src_done = '0;
    flush_start();
    for (int r = 0; r <= 15; r++) begin
      if (r > 0) tick();
      src_done = (r >= 7) ? 4'b0100 : 4'b0000;
      drive();
      #1;
      take_beat(s);
      if (s >= 0) chk("t4_src", s, (r == 6) ? 2 : 3);
      if (r == 7) begin
        chk("t4_done_ready", 32'(src_ready), 0);
        chk("t4_done_valid", 32'(out_valid), 0);
        chk("t4_done_grant", 32'(grant_id), 2);
      end
      if (r == 8) chk("t4_arb_valid", 32'(out_valid), 0);
      if (r == 9) chk("t4_next_grant", 32'(grant_id), 3);
      if (r == 14) begin
        chk("t4_regrant", 32'(grant_id), 3);
        chk("t4_regrant_ready", 32'(src_ready), 'b1000);
      end
    end
    chk("t4_src2_beats", n[2], 1);
    chk("t4_src3_beats", n[3], 6);
    src_done = '0;

    // Test 5: flush during src1's burst; restart must begin from source 0
    setup('h700, 100, 'h780, 100, 0, 0, 0, 0);
    flush_start();
    for (int r = 0; r <= 20; r++) begin
      if (r > 0) tick();
      flush = (r == 13);
      drive();
      #1;
      take_beat(s);
      if (r == 13) begin
        chk("t5_flush_valid", 32'(out_valid), 0);
        chk("t5_flush_ready", 32'(src_ready), 0);
      end
      if (r == 14) begin
        chk("t5_idle_valid", 32'(out_valid), 0);
        chk("t5_idle_data", 32'(out_data), 0);
      end
      if (r == 19) chk("t5_arb_valid", 32'(out_valid), 0);
      if (r == 20) begin
        chk("t5_restart_grant", 32'(grant_id), 0);
        chk("t5_restart_src", s, 0);
      end
    end
    chk("t5_src0_beats", n[0], 5);
    chk("t5_src1_beats", n[1], 2);

    // Test 6: asynchronous reset between edges, mid-burst
    tick();
    drive();
    #1;
    chk("t6_pre_valid", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_data", 32'(out_data), 0);
    chk("t6_ready", 32'(src_ready), 0);
    chk("t6_grant", 32'(grant_id), 0);
    chk("t6_all_done", 32'(all_done), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      drive();
    end
    #1;
    chk("t6_post_valid", 32'(out_valid), 0);
    chk("t6_post_ready", 32'(src_ready), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
